queue_ctrl: RTL and testbench

QUEUE_CTRL -- requirements
Module: queue_ctrl

---
 rtl/queue_ctrl_if.sv | 52 +++++
 rtl/queue_ctrl.sv | 98 +++++++++
 tb/tb_queue_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/queue_ctrl_if.sv
// queue_ctrl_if -- the bundle of signals around queue_ctrl.
//
// Groups the producer/consumer request signals, the registered status
// outputs and the external single-port-per-direction RAM connection.
//
//   slave  : the queue controller side (queue_ctrl itself)
//   master : the user side (requests in, status and RAM model out)
//
// Handshake semantics (one rule for both directions):
//   push is a request, !full is the ready. A push is accepted on a rising
//   clk edge only if push=1 while the registered full flag is 0.
//   pop is a request, !empty is the ready. A pop is accepted only if pop=1
//   while the registered empty flag is 0. pop_valid rises exactly one clk
//   after an accepted pop, with the popped word on pop_data.
//   A request made while not ready is dropped and latches overflow or
//   underflow. There is no back-pressure and no retry.
interface queue_ctrl_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
);
    logic              push;
    logic [DWIDTH-1:0] push_data;
    logic              pop;
    logic [DWIDTH-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [AWIDTH:0]   count;
    logic              overflow;
    logic              underflow;
    logic [AWIDTH-1:0] ram_addr0;
    logic [DWIDTH-1:0] ram_data0;
    logic              ram_we0;
    logic [AWIDTH-1:0] ram_addr1;
    logic              ram_re1;
    logic [DWIDTH-1:0] ram_q1;

    modport slave (
        input  push, push_data, pop, ram_q1,
        output pop_data, pop_valid, full, empty, almost_full, count,
               overflow, underflow, ram_addr0, ram_data0, ram_we0,
               ram_addr1, ram_re1
    );

    modport master (
        output push, push_data, pop, ram_q1,
        input  pop_data, pop_valid, full, empty, almost_full, count,
               overflow, underflow, ram_addr0, ram_data0, ram_we0,
               ram_addr1, ram_re1
    );
endinterface

// File: rtl/queue_ctrl.sv
// queue_ctrl -- FIFO controller for an external RAM with a registered read port.
//
// Keeps wrap-bit write/read pointers, a registered occupancy count and
// registered empty/full/almost_full flags. It also keeps sticky
// overflow/underflow error flags. The RAM itself lives outside this block.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : queue_ctrl_if.slave
//            push/push_data, pop      requests
//            pop_data/pop_valid       popped word, one clk after the pop
//            full/empty/almost_full   registered occupancy flags
//            count                    registered occupancy, 0..2^AWIDTH
//            overflow/underflow       sticky until rst
//            ram_addr0/ram_data0/ram_we0   RAM write port
//            ram_addr1/ram_re1/ram_q1      RAM read port (q1 valid 1 clk after re1)
module queue_ctrl #(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 8,
    parameter int AF_LEVEL = (1 << AWIDTH) - 2
) (
    input  logic        clk,
    input  logic        rst,
    queue_ctrl_if.slave bus
);
    localparam int              DEPTH_I = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH   = DEPTH_I[AWIDTH:0];
    localparam logic [AWIDTH:0] AF_LVL  = AF_LEVEL[AWIDTH:0];

    logic [AWIDTH:0] wr_ptr;
    logic [AWIDTH:0] rd_ptr;
    logic [AWIDTH:0] count_q;
    logic [AWIDTH:0] count_nxt;
    logic            full_q;
    logic            empty_q;
    logic            af_q;
    logic            pop_valid_q;
    logic            overflow_q;
    logic            underflow_q;
    logic            push_acc;
    logic            pop_acc;

    // Acceptance looks only at the registered flags. A same-cycle pop does
    // not make room for a push at full, and a same-cycle push does not
    // feed a pop at empty.
    assign push_acc = bus.push & ~full_q  & ~rst;
    assign pop_acc  = bus.pop  & ~empty_q & ~rst;

    always_comb begin
        count_nxt = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            // A zero threshold means "almost full" even when empty.
            af_q        <= (AF_LVL == '0);
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // Pointers carry a wrap bit and roll over naturally.
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            count_q     <= count_nxt;
            empty_q     <= (count_nxt == '0);
            full_q      <= (count_nxt == DEPTH);
            af_q        <= (count_nxt >= AF_LVL);
            pop_valid_q <= pop_acc;
            if (bus.push && full_q)  overflow_q  <= 1'b1;
            if (bus.pop  && empty_q) underflow_q <= 1'b1;
        end
    end

    assign bus.ram_addr0   = wr_ptr[AWIDTH-1:0];
    assign bus.ram_data0   = bus.push_data;
    assign bus.ram_we0     = push_acc;
    assign bus.ram_addr1   = rd_ptr[AWIDTH-1:0];
    assign bus.ram_re1     = pop_acc;
    assign bus.pop_data    = bus.ram_q1;
    assign bus.pop_valid   = pop_valid_q;
    assign bus.count       = count_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.almost_full = af_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_queue_ctrl.sv
// tb_queue_ctrl -- self-checking bench for queue_ctrl (DWIDTH=8, AWIDTH=2, AF_LEVEL=3).
//
// Holds a small RAM model with a registered read port. A reference model
// keeps the queue contents as a plain SV queue and derives every expected
// output from the queue length.
module tb_queue_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int AF    = 3;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    queue_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) q ();

    queue_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .AF_LEVEL(AF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (q)
    );

    // External RAM with a registered read port
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q1;
    always_ff @(posedge clk) begin
        if (q.ram_we0) mem[q.ram_addr0] <= q.ram_data0;
        if (q.ram_re1) ram_q1 <= mem[q.ram_addr1];
    end
    assign q.ram_q1 = ram_q1;

    // ---------------- scoreboard / reference model ----------------
    logic [DW-1:0] exp_q[$];
    int            m_wr  = 0;   // write position, counts modulo 2*DEPTH
    int            m_rd  = 0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            m_pend = 1'b0;
    logic [DW-1:0] m_word = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One clock of stimulus. Combinational RAM-port outputs are checked
    // mid-cycle. Registered outputs are checked just after the edge.
    task automatic cycle(input logic r, input logic pu, input logic po, input logic [DW-1:0] d);
        bit pa;
        bit oa;
        rst         = r;
        q.push      = pu;
        q.pop       = po;
        q.push_data = d;
        @(negedge clk);
        pa = !r && pu && (exp_q.size() < DEPTH);
        oa = !r && po && (exp_q.size() > 0);
        check("ram_we0", 32'(q.ram_we0), 32'(pa));
        check("ram_re1", 32'(q.ram_re1), 32'(oa));
        check("ram_data0", 32'(q.ram_data0), 32'(d));
        if (!r) begin
            check("ram_addr0", 32'(q.ram_addr0), 32'(m_wr % DEPTH));
            check("ram_addr1", 32'(q.ram_addr1), 32'(m_rd % DEPTH));
        end
        if (r) begin
            exp_q.delete();
            m_wr = 0; m_rd = 0; m_ovf = 1'b0; m_unf = 1'b0; m_pend = 1'b0;
        end else begin
            m_pend = oa;
            if (oa) begin
                m_word = exp_q.pop_front();
                m_rd   = (m_rd + 1) % (2 * DEPTH);
            end
            if (pa) begin
                exp_q.push_back(d);
                m_wr = (m_wr + 1) % (2 * DEPTH);
            end
            if (pu && !pa) m_ovf = 1'b1;
            if (po && !oa) m_unf = 1'b1;
        end
        @(posedge clk);
        #1;
        check("count", 32'(q.count), 32'(exp_q.size()));
        check("empty", 32'(q.empty), 32'(exp_q.size() == 0));
        check("full", 32'(q.full), 32'(exp_q.size() == DEPTH));
        check("almost_full", 32'(q.almost_full), 32'(exp_q.size() >= AF));
        check("overflow", 32'(q.overflow), 32'(m_ovf));
        check("underflow", 32'(q.underflow), 32'(m_unf));
        check("pop_valid", 32'(q.pop_valid), 32'(m_pend));
        if (m_pend) check("pop_data", 32'(q.pop_data), 32'(m_word));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bias;
        logic [DW-1:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        q.push = 1'b0; q.pop = 1'b0; q.push_data = '0;

        // Reset with requests present: they must be ignored
        cycle(1'b1, 1'b1, 1'b1, 8'h99);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);

        // Fill: 0x11..0x44
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, words[i]);
        check("fill_full", 32'(q.full), 32'd1);
        check("fill_count", 32'(q.count), 32'd4);

        // Push while full -> rejected, overflow sticks
        cycle(1'b0, 1'b1, 1'b0, 8'h55);
        // Push while full with a same-cycle pop: the push is still rejected
        cycle(1'b0, 1'b1, 1'b1, 8'h66);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("ovf_sticky", 32'(q.overflow), 32'd1);

        // Drain the remaining 3 entries
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check("drain_empty", 32'(q.empty), 32'd1);

        // Pop when empty with a same-cycle push 0xAA
        cycle(1'b0, 1'b1, 1'b1, 8'hAA);
        check("pop_empty_count", 32'(q.count), 32'd1);
        check("pop_empty_unf", 32'(q.underflow), 32'd1);

        // Reach count 2, then push and pop together for 10 cycles (pointers wrap)
        cycle(1'b0, 1'b1, 1'b0, 8'hB0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 8'(8'hC0 + i));
        check("steady_count", 32'(q.count), 32'd2);

        // Reset with count 3 and a pop_valid pending
        cycle(1'b0, 1'b1, 1'b0, 8'hD1);
        cycle(1'b0, 1'b1, 1'b0, 8'hD2);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_mid_count", 32'(q.count), 32'd0);
        check("rst_mid_pv", 32'(q.pop_valid), 32'd0);

        // Randomized traffic with shifting push/pop bias and rare resets
        bias = 50;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) bias = $urandom_range(15, 85);
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < (100 - bias)) ? 1'b1 : 1'b0,
                  8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
